// File: rtl/granule_reorder_buffer.sv
// rtl/granule_reorder_buffer.sv - Ping-pong granule buffer reordering Layer III short blocks into subband order
// Samples are written at their reordered address and drained sequentially, so the reorder costs no extra latency.
module granule_reorder_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  window_switching_flag,
    input  logic [1:0]            block_type,
    input  logic                  mixed_block_flag,
    input  logic [1:0]            sr_index,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam logic [9:0] LAST_LINE  = 10'd575;
    localparam logic [9:0] MIXED_LONG = 10'd36;

    typedef enum logic [1:0] {MODE_LONG, MODE_SHORT, MODE_MIXED} mode_e;

    function automatic logic [6:0] sfb_width(input logic [1:0] sr, input logic [3:0] sfb);
        logic [6:0] w;
        w = 7'd4;
        case (sr)
            2'd1: case (sfb)
                4'd4: w = 7'd6;   4'd5: w = 7'd6;   4'd6: w = 7'd10;
                4'd7: w = 7'd12;  4'd8: w = 7'd14;  4'd9: w = 7'd16;
                4'd10: w = 7'd20; 4'd11: w = 7'd26; 4'd12: w = 7'd66;
                default: w = 7'd4;
            endcase
            2'd2: case (sfb)
                4'd4: w = 7'd6;   4'd5: w = 7'd8;   4'd6: w = 7'd12;
                4'd7: w = 7'd16;  4'd8: w = 7'd20;  4'd9: w = 7'd26;
                4'd10: w = 7'd34; 4'd11: w = 7'd42; 4'd12: w = 7'd12;
                default: w = 7'd4;
            endcase
            default: case (sfb)
                4'd4: w = 7'd6;   4'd5: w = 7'd8;   4'd6: w = 7'd10;
                4'd7: w = 7'd12;  4'd8: w = 7'd14;  4'd9: w = 7'd18;
                4'd10: w = 7'd22; 4'd11: w = 7'd30; 4'd12: w = 7'd56;
                default: w = 7'd4;
            endcase
        endcase
        return w;
    endfunction

    // Writer state
    logic [9:0]  wc_q, wc_d;
    mode_e       mode_q, mode_d;
    logic [1:0]  sr_q, sr_d;
    logic [3:0]  sfb_q, sfb_d;
    logic [1:0]  win_q, win_d;
    logic [6:0]  j_q, j_d;
    logic [9:0]  start_q, start_d;
    logic        wb_q, wb_d;
    logic [1:0]  full_q, full_d;
    logic [1:0][TAG_WIDTH-1:0] bank_tag_q, bank_tag_d;

    // Reader state
    logic                  rb_q, rb_d;
    logic [9:0]            rc_q, rc_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;
    logic                  s1_last_q, s1_last_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
    logic                  out_last_q, out_last_d;

    logic                  wr_fire, wr_first, use_short;
    mode_e                 mode_in, cur_mode;
    logic [1:0]            sr_in, cur_sr;
    logic [3:0]            eff_sfb;
    logic [1:0]            eff_win;
    logic [6:0]            eff_j, cur_w;
    logic [9:0]            eff_start, wr_addr;
    logic                  rd_fire, out_can, s1_adv;

    logic [DATA_WIDTH-1:0] mem [2][576];
    logic [DATA_WIDTH-1:0] ram_rdata_q;

    assign in_ready = !full_q[wb_q] && !rst;

    always_comb begin
        wr_fire  = in_valid && in_ready;
        wr_first = (wc_q == 10'd0);
        if (window_switching_flag && block_type == 2'd2)
            mode_in = mixed_block_flag ? MODE_MIXED : MODE_SHORT;
        else
            mode_in = MODE_LONG;
        sr_in    = (sr_index == 2'd3) ? 2'd0 : sr_index;
        cur_mode = wr_first ? mode_in : mode_q;
        cur_sr   = wr_first ? sr_in : sr_q;
        // Line 0 maps to address 0 in every mode, so the first sample can use seeded counters directly
        if (wr_first) begin
            eff_sfb   = (mode_in == MODE_MIXED) ? 4'd3 : 4'd0;
            eff_start = (mode_in == MODE_MIXED) ? MIXED_LONG : 10'd0;
            eff_win   = 2'd0;
            eff_j     = 7'd0;
        end else begin
            eff_sfb   = sfb_q;
            eff_start = start_q;
            eff_win   = win_q;
            eff_j     = j_q;
        end
        use_short = (cur_mode == MODE_SHORT) || (cur_mode == MODE_MIXED && wc_q >= MIXED_LONG);
        cur_w     = sfb_width(cur_sr, eff_sfb);
        wr_addr   = use_short ? (eff_start + 10'(eff_j) * 10'd3 + 10'(eff_win)) : wc_q;
    end

    always_comb begin
        wc_d    = wc_q;
        mode_d  = mode_q;
        sr_d    = sr_q;
        sfb_d   = sfb_q;
        win_d   = win_q;
        j_d     = j_q;
        start_d = start_q;
        wb_d    = wb_q;
        if (wr_fire) begin
            mode_d  = cur_mode;
            sr_d    = cur_sr;
            sfb_d   = eff_sfb;
            win_d   = eff_win;
            j_d     = eff_j;
            start_d = eff_start;
            if (use_short) begin
                if (eff_j == cur_w - 7'd1) begin
                    j_d = 7'd0;
                    if (eff_win == 2'd2) begin
                        win_d   = 2'd0;
                        sfb_d   = eff_sfb + 4'd1;
                        start_d = eff_start + 10'(cur_w) * 10'd3;
                    end else begin
                        win_d = eff_win + 2'd1;
                    end
                end else begin
                    j_d = eff_j + 7'd1;
                end
            end
            if (wc_q == LAST_LINE) begin
                wc_d = 10'd0;
                wb_d = !wb_q;
            end else begin
                wc_d = wc_q + 10'd1;
            end
        end
    end

    // A bank is released once its last line is read out of the RAM; the tail lives on in the output pipeline
    always_comb begin
        full_d     = full_q;
        bank_tag_d = bank_tag_q;
        if (wr_fire && wr_first)
            bank_tag_d[wb_q] = in_tag;
        if (wr_fire && wc_q == LAST_LINE)
            full_d[wb_q] = 1'b1;
        if (rd_fire && rc_q == LAST_LINE)
            full_d[rb_q] = 1'b0;
    end

    always_comb begin
        out_can    = !out_valid_q || out_ready;
        s1_adv     = s1_valid_q && out_can;
        rd_fire    = full_q[rb_q] && (!s1_valid_q || out_can);
        rb_d       = rb_q;
        rc_d       = rc_q;
        s1_valid_d = s1_valid_q;
        s1_tag_d   = s1_tag_q;
        s1_last_d  = s1_last_q;
        if (rd_fire) begin
            s1_valid_d = 1'b1;
            s1_tag_d   = bank_tag_q[rb_q];
            s1_last_d  = (rc_q == LAST_LINE);
            if (rc_q == LAST_LINE) begin
                rc_d = 10'd0;
                rb_d = !rb_q;
            end else begin
                rc_d = rc_q + 10'd1;
            end
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_last_d  = out_last_q;
        if (out_can) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = ram_rdata_q;
                out_tag_d  = s1_tag_q;
                out_last_d = s1_last_q;
            end else begin
                out_last_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wb_q][wr_addr] <= in_data;
        if (rd_fire)
            ram_rdata_q <= mem[rb_q][rc_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wc_q        <= 10'd0;
            mode_q      <= MODE_LONG;
            sr_q        <= 2'd0;
            sfb_q       <= 4'd0;
            win_q       <= 2'd0;
            j_q         <= 7'd0;
            start_q     <= 10'd0;
            wb_q        <= 1'b0;
            full_q      <= 2'b00;
            bank_tag_q  <= '0;
            rb_q        <= 1'b0;
            rc_q        <= 10'd0;
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            wc_q        <= wc_d;
            mode_q      <= mode_d;
            sr_q        <= sr_d;
            sfb_q       <= sfb_d;
            win_q       <= win_d;
            j_q         <= j_d;
            start_q     <= start_d;
            wb_q        <= wb_d;
            full_q      <= full_d;
            bank_tag_q  <= bank_tag_d;
            rb_q        <= rb_d;
            rc_q        <= rc_d;
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/granule_reorder_buffer.md
# granule_reorder_buffer

Reorders one granule/channel (576 dequantised frequency lines) of MPEG-1 Layer III data from Huffman/short-block order into subband order, writing samples at a reordered address as they arrive. It sits between the requantiser and the stereo/antialias stages. Unlike the earlier index-remap stage, it buffers the sample data itself in a two-bank ping-pong RAM, derives short-block addresses arithmetically from per-sample-rate sfb width tables, and uses valid/ready handshakes on both sides.

## Interface
- DATA_WIDTH, 32, sample width in bits
- TAG_WIDTH, 2, granule/channel tag width carried alongside each granule
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  DATA_WIDTH  frequency-line sample, arrives in bitstream order
- in_tag  in  TAG_WIDTH  gr/ch tag; sampled on the first handshake of a granule
- in_valid  in  1  sample valid
- in_ready  out  1  block can accept a sample
- window_switching_flag  in  1  side info; sampled on the first handshake of a granule
- block_type  in  2  side info; sampled on the first handshake of a granule
- mixed_block_flag  in  1  side info; sampled on the first handshake of a granule
- sr_index  in  2  0=44.1k, 1=48k, 2=32k, 3 treated as 0; sampled on the first handshake of a granule
- out_data  out  DATA_WIDTH  reordered sample
- out_tag  out  TAG_WIDTH  tag of the granule being drained
- out_last  out  1  high with line 575
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts

## Operation
- Two banks of 576×DATA_WIDTH single-port-write/single-port-read RAM, with 1-cycle registered read. Each bank has a full flag and a stored tag/mode.
- Writer: a 10-bit line counter wc runs 0..575 and advances on in_valid&&in_ready.
  - At wc=575 the handshake sets the current bank full, resets wc to 0 and toggles the write bank.
  - in_ready = !full[write bank] && !rst.
- Mode, latched per granule: SHORT when window_switching_flag && block_type==2. MIXED when SHORT && mixed_block_flag. Otherwise LONG.
- LONG: the write address is wc.
- SHORT/MIXED: write-side counters sfb (0..12), win (0..2), j (0..width-1), plus sfb_start.
  - Write address = sfb_start + 3·j + win.
  - j wraps to 0 and increments win. When win wraps to 0, sfb_start += 3·width and sfb increments.
- MIXED: lines 0..35 are written at address wc. Short counters start at sfb=3, sfb_start=36, taking effect when wc=36.
- Short sfb widths:
  - 44.1k: 4,4,4,4,6,8,10,12,14,18,22,30,56
  - 48k: 4,4,4,4,6,6,10,12,14,16,20,26,66
  - 32k: 4,4,4,4,6,8,12,16,20,26,34,42,12
  - Each table sums to 192, so 3×192 = 576.
- Reader: drains the oldest full bank sequentially at addresses 0..575, in order of bank fill.
  - After handshaking line 575 it clears that bank's full flag and toggles the read bank.
- Output stage: RAM read register plus a 1-entry skid register. This sustains 1 sample/cycle under continuous out_ready and loses nothing on stalls.
- out_data/out_tag/out_last are held stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=0 during rst and 1 on the first cycle after. out_valid=0, out_last=0, out_data=0, out_tag=0.
- Reset clears wc, the short counters, both full flags, and the read/write bank pointers. Reset mid-granule discards all partial and buffered data; the RAM contents are don't-care.
- Latency: the last input handshake at cycle T sets full at T+1. First out_valid at T+3 when the read bank was idle.
- Throughput: 1 line/cycle in and out. A continuous stream with out_ready=1 never deasserts in_ready.
- Both banks full: in_ready=0 until the reader clears a bank. in_ready rises the cycle after the clear.
- Writing bank A and draining bank B in the same cycle is legal. A full flag set and a clear of the other bank in the same cycle are both honoured.
- Side-info inputs are ignored except on the first handshake of a granule. Changes mid-granule have no effect.

## Test plan
- LONG, in_data=line index 0..575, out_ready=1: out_data=0,1,…,575; out_last only on 575; first out_valid 3 cycles after the last input.
- SHORT, 44.1k, in_data=index: output begins 0,4,8,1,5,9,2,6,10,3,7,11,12,16,20,13. Line 575 comes from input 575 (sfb12 win2 j55).
- MIXED, 48k: outputs 0..35 are identity, then 36,40,44,37,41,45. 32k SHORT: last 36 outputs are sfb12, width 12, interleaved 540,552,564,541,….
- Backpressure: out_ready held low while 3 granules are sent → in_ready drops after exactly 1152 accepted lines. Releasing out_ready drains granules in order with correct tags (tags 0,1,2) and no duplicated or lost samples.
- Random out_ready at 50% plus random in_valid across 8 granules of mixed modes: output matches the golden reorder model bit-exactly.
- rst asserted after line 300 of a granule: next cycle out_valid=0. After release, in_ready=1, and a fresh LONG granule outputs 0..575 with no stale data.
